// File: rtl/truth_table_checker.sv
// Sweeps all 16 input vectors of a 4-input combinational block, holds each for
// SETTLE cycles, samples f on the last cycle and compares it with EXPECTED.
module truth_table_checker #(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int unsigned SETTLE   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] err_mask
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] LAST_DWELL = 8'(SETTLE - 1);

    state_t     state;
    logic [3:0] vec;
    logic [7:0] dwell;
    logic       mismatch;
    logic [4:0] err_next;

    always_comb begin
        mismatch = (f != EXPECTED[vec]);
        err_next = err_count + {4'd0, mismatch};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec          <= 4'd0;
            dwell        <= 8'd0;
            {a, b, c, d} <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= 5'd0;
            err_mask     <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RUN;
                        vec          <= 4'd0;
                        dwell        <= 8'd0;
                        {a, b, c, d} <= 4'd0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        err_count    <= 5'd0;
                        err_mask     <= 16'd0;
                    end
                end
                RUN: begin
                    // Last cycle of the window: the vector has been stable for SETTLE cycles.
                    if (dwell == LAST_DWELL) begin
                        if (mismatch) begin
                            err_mask[vec] <= 1'b1;
                        end
                        err_count <= err_next;
                        dwell     <= 8'd0;
                        if (vec == 4'd15) begin
                            state        <= DONE;
                            vec          <= 4'd0;
                            {a, b, c, d} <= 4'd0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            pass         <= (err_next == 5'd0);
                        end else begin
                            vec          <= vec + 4'd1;
                            {a, b, c, d} <= vec + 4'd1;
                        end
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (xor/SETTLE=20, stuck-at-0,
// xor/SETTLE=1) driven by directed sweeps; results land in an expected queue.
module tb_truth_table_checker;

    localparam int W = 40;  // {id[1:0], latency[15:0], pass, err_count[4:0], err_mask[15:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic        fault_en = 1'b0;

    logic [2:0]  a_w, b_w, c_w, d_w, busy_w, done_w, pass_w;
    logic [4:0]  errc_w [3];
    logic [15:0] mask_w [3];
    logic        f_xor, f_fast;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    // Reference model state: cycle counter, per-instance start edge and activity.
    int   cyc = 0;
    int   start_cyc [3] = '{0, 0, 0};
    logic [2:0] active = 3'b000;
    logic [2:0] done_prev = 3'b000;

    always #5 clk = ~clk;

    assign f_xor  = a_w[0] ^ b_w[0] ^ c_w[0] ^ d_w[0] ^ (fault_en && {a_w[0], b_w[0], c_w[0], d_w[0]} == 4'd5);
    assign f_fast = a_w[2] ^ b_w[2] ^ c_w[2] ^ d_w[2];

    truth_table_checker #(.EXPECTED(16'h6996), .SETTLE(20)) u_xor (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .f(f_xor),
        .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(errc_w[0]), .err_mask(mask_w[0])
    );

    truth_table_checker #(.EXPECTED(16'hA5C3), .SETTLE(20)) u_stuck (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .f(1'b0),
        .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(errc_w[1]), .err_mask(mask_w[1])
    );

    truth_table_checker #(.EXPECTED(16'h6996), .SETTLE(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .f(f_fast),
        .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .d(d_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(errc_w[2]), .err_mask(mask_w[2])
    );

    function automatic int settle_of(input int k);
        return (k == 2) ? 1 : 20;
    endfunction

    function automatic logic model_busy(input int k);
        return active[k] && ((cyc - start_cyc[k]) < 16 * settle_of(k));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                active[k] <= 1'b0;
            end else if (start_v[k] && !model_busy(k)) begin
                active[k]    <= 1'b1;
                start_cyc[k] <= cyc + 1;
            end
        end
        cyc <= cyc + 1;
    end

    // Monitor: per-cycle vector/busy/done checks, and a scoreboard pop on each done rise.
    always @(negedge clk) begin
        int          rel;
        logic        bexp;
        logic        dexp;
        logic [3:0]  vexp;
        logic [W-1:0] item;
        logic [W-1:0] got;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                rel  = cyc - start_cyc[k];
                bexp = model_busy(k);
                dexp = active[k] && (rel >= 16 * settle_of(k));
                vexp = bexp ? 4'(rel / settle_of(k)) : 4'd0;
                check($sformatf("busy[%0d]", k), 64'(busy_w[k]), 64'(bexp));
                check($sformatf("done[%0d]", k), 64'(done_w[k]), 64'(dexp));
                check($sformatf("vec[%0d]", k), 64'({a_w[k], b_w[k], c_w[k], d_w[k]}), 64'(vexp));
                if (done_w[k] && !done_prev[k]) begin
                    got = {2'(k), 16'(rel), pass_w[k], errc_w[k], mask_w[k]};
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_done[%0d]", k), 64'(got), 64'(0));
                    end else begin
                        item = exp_q.pop_front();
                        check($sformatf("result[%0d]", k), 64'(got), 64'(item));
                    end
                end
            end
        end
        done_prev <= done_w;
    end

    task automatic push_exp(input int k, input logic p, input logic [4:0] ec, input logic [15:0] m);
        exp_q.push_back({2'(k), 16'(16 * settle_of(k)), p, ec, m});
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_w[k]) break;
            @(negedge clk);
        end
        check($sformatf("done_timeout[%0d]", k), 64'(done_w[k]), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input int k, input string tag);
        check($sformatf("%s_outs[%0d]", tag, k),
              64'({a_w[k], b_w[k], c_w[k], d_w[k], busy_w[k], done_w[k], pass_w[k]}), 64'(0));
        check($sformatf("%s_errc[%0d]", tag, k), 64'(errc_w[k]), 64'(0));
        check($sformatf("%s_mask[%0d]", tag, k), 64'(mask_w[k]), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) check_zero(k, "reset");
        mon_en = 1'b1;

        // All vectors match.
        push_exp(0, 1'b1, 5'd0, 16'h0000);
        pulse_start(0);
        wait_done(0, 400);

        // f inverted only for vector 5.
        fault_en = 1'b1;
        push_exp(0, 1'b0, 5'd1, 16'h0020);
        pulse_start(0);
        wait_done(0, 400);
        fault_en = 1'b0;

        // Extra start around cycle 100 must be ignored.
        push_exp(0, 1'b1, 5'd0, 16'h0000);
        pulse_start(0);
        repeat (98) @(negedge clk);
        pulse_start(0);
        wait_done(0, 400);

        // Reset during vector 7 aborts the sweep; a fresh start then completes.
        pulse_start(0);
        repeat (7 * 20 + 4) @(negedge clk);
        check("pre_reset_vec", 64'({a_w[0], b_w[0], c_w[0], d_w[0]}), 64'(7));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero(0, "midrst");
        push_exp(0, 1'b1, 5'd0, 16'h0000);
        pulse_start(0);
        wait_done(0, 400);

        // Stuck-at-0 output against a table with eight ones.
        push_exp(1, 1'b0, 5'd8, 16'hA5C3);
        pulse_start(1);
        wait_done(1, 400);

        // SETTLE = 1: two back-to-back sweeps, the second started from DONE.
        push_exp(2, 1'b1, 5'd0, 16'h0000);
        pulse_start(2);
        wait_done(2, 40);
        push_exp(2, 1'b1, 5'd0, 16'h0000);
        pulse_start(2);
        wait_done(2, 40);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesisable sequential driver/checker for a 4-input, 1-output combinational block.
- Walks all 16 input vectors {a,b,c,d} in ascending order, with a as MSB.
- Holds each vector for a programmable settle time, then samples the block's output f and compares it with a parameterised expected truth table.
- Reports per-vector mismatches, an error count and pass/fail.
- Sits beside the combinational lab blocks and lets their outputs be checked on-chip or in simulation without a hand-written stimulus bench.

Parameters:
- EXPECTED, 16'h0000, expected f for each vector. Bit i is the expected f when {a,b,c,d} == i.
- SETTLE, 20, clock cycles each vector is held. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- f  input  1  output of the block under check.
- a  output  1  vector bit 3, MSB.
- b  output  1  vector bit 2.
- c  output  1  vector bit 1.
- d  output  1  vector bit 0, LSB.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  valid while done is high; 1 when err_count == 0.
- err_count  output  5  number of mismatching vectors, 0..16.
- err_mask  output  16  bit i set when vector i mismatched.

Behaviour:
- Reset: only one clock; rst_n is sampled on the rising clk edge only.
  - When rst_n == 0 at an edge, all outputs go to 0: a, b, c, d, busy, done, pass, err_count, err_mask.
  - The internal vector and dwell counters clear to 0 and the FSM returns to IDLE.
  - Reset takes priority over start and over everything else. A reset mid-sweep aborts the sweep; no partial result is kept.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - {a,b,c,d} = 0, busy = 0.
  - start == 1 → RUN. On that same edge: vec = 0, dwell = 0, err_mask = 0, err_count = 0, done = 0, pass = 0, busy = 1.
- RUN:
  - {a,b,c,d} = vec, registered outputs.
  - dwell increments every cycle from 0 to SETTLE-1.
  - On the edge where dwell == SETTLE-1, f is sampled and compared with EXPECTED[vec]:
    - On mismatch, err_mask[vec] is set and err_count increments.
    - If vec == 15 → DONE. Otherwise vec increments and dwell restarts at 0.
  - start is ignored while in RUN.
- DONE:
  - busy = 0, done = 1, pass = (final err_count == 0).
  - {a,b,c,d} returns to 0. err_mask and err_count hold.
  - start == 1 → RUN, with the same clearing as from IDLE.
- Timing, with the start edge as cycle 0:
  - Vector i is driven during cycles 1+i*SETTLE through (i+1)*SETTLE.
  - f is sampled in the last cycle of each window.
  - done rises at the edge ending cycle 16*SETTLE, so it is visible from cycle 16*SETTLE+1.
- Combinational DUT assumption: f is compared without a synchroniser. SETTLE ≥ 1 guarantees at least one full cycle of settling.
- Widths and wrap-around:
  - err_count is 5 bits, so 16 mismatches is representable without wrap.
  - vec is 4 bits and never wraps inside a sweep; the terminal condition is tested on 15.
- Counter reuse: dwell is 8 bits. When SETTLE == 1, every RUN cycle is a sample cycle.

Test Plan:
- Default match: EXPECTED = 16'h6996, DUT f = a^b^c^d, SETTLE = 20, start pulse at cycle 0.
  - vectors 0..15 each held 20 cycles.
  - done = 1 at cycle 321, busy = 0, pass = 1, err_count = 0, err_mask = 0.
- Single fault: same setup, but the DUT model inverts f only for vector 5 → err_mask = 16'h0020, err_count = 1, pass = 0.
- Stuck-at-0: EXPECTED = 16'hA5C3, f tied 0 → err_count = 8, err_mask = 16'hA5C3, pass = 0.
- start while busy: extra start pulse at cycle 100 → ignored; done still at cycle 321 and results identical to the first scenario.
- Reset mid-run: rst_n = 0 for one edge during vector 7.
  - Next cycle: all outputs 0, busy = 0.
  - A fresh start then completes a full sweep with correct results.
- SETTLE = 1 instance, f = a^b^c^d, EXPECTED = 16'h6996 → vector changes every cycle, done visible at cycle 17, pass = 1; a second start from DONE repeats the sweep with identical results.
